// File: rtl/riscv_multicycle_controller_if.sv
// riscv_multicycle_controller_if: control bus between the multicycle FSM and its datapath.
//   Decode inputs: Op, Funct3, Funct7, Zero, mem_ready, halt_req.
//   Control outputs: PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
//   ALUSrcA, ALUSrcB, ALUControl, ImmSrc, halted, state_out.
//   master = controller side, slave = datapath side.
interface riscv_multicycle_controller_if;
   logic [6:0] Op;
   logic [2:0] Funct3;
   logic [6:0] Funct7;
   logic       Zero;
   logic       mem_ready;
   logic       halt_req;
   logic       PCWrite;
   logic       AdrSrc;
   logic       IRWrite;
   logic       MemWrite;
   logic       RegWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [3:0] ALUControl;
   logic [3:0] ImmSrc;
   logic       halted;
   logic [3:0] state_out;
   modport master (
      input  Op, Funct3, Funct7, Zero, mem_ready, halt_req,
      output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl, ImmSrc, halted, state_out
   );
   modport slave (
      output Op, Funct3, Funct7, Zero, mem_ready, halt_req,
      input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl, ImmSrc, halted, state_out
   );
endinterface

// File: rtl/riscv_multicycle_controller.sv
// riscv_multicycle_controller: Moore control FSM for a shared-memory multicycle RV32I datapath.
//   Clock : rising-edge clock
//   Reset : synchronous active-high reset, returns to FETCH and zeroes every control output
//   bus   : master side of riscv_multicycle_controller_if (decode inputs in, enables/selects out)
module riscv_multicycle_controller #(
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic                           Clock,
   input  logic                           Reset,
   riscv_multicycle_controller_if.master  bus
);
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
      ALUWB, BRANCH, JAL, JALR, UPPER, HALT, TRAP, UNUSED
   } state_t;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                          ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                          ALU_SRL = 4'd8, ALU_SRA = 4'd9;
   state_t state, next;
   logic       pcw, adr, irw, memw, regw;
   logic [1:0] res, sa, sb;
   logic [3:0] alu, imm;
   logic       unused_f7;
   assign unused_f7 = ^{bus.Funct7[6], bus.Funct7[4:0]};
   // alt selects sub (funct3 000) or sra (funct3 101)
   function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  alu_map = alt ? ALU_SUB : ALU_ADD;
         3'b001:  alu_map = ALU_SLL;
         3'b010:  alu_map = ALU_SLT;
         3'b011:  alu_map = ALU_SLTU;
         3'b100:  alu_map = ALU_XOR;
         3'b101:  alu_map = alt ? ALU_SRA : ALU_SRL;
         3'b110:  alu_map = ALU_OR;
         default: alu_map = ALU_AND;
      endcase
   endfunction
   always_ff @(posedge Clock)
      state <= Reset ? state_t'(RESET_STATE) : next;
   always_comb begin
      next = FETCH;
      case (state)
         FETCH:    next = bus.halt_req ? HALT : bus.mem_ready ? DECODE : FETCH;
         DECODE:
            case (bus.Op)
               OP_LOAD, OP_STORE: next = MEMADR;
               OP_R:              next = EXECR;
               OP_I:              next = EXECI;
               OP_BR:             next = BRANCH;
               OP_JAL:            next = JAL;
               OP_JALR:           next = JALR;
               OP_LUI, OP_AUIPC:  next = UPPER;
               default:           next = TRAP;
            endcase
         MEMADR:   next = (bus.Op == OP_STORE) ? MEMWRITE : MEMREAD;
         MEMREAD:  next = bus.mem_ready ? MEMWB : MEMREAD;
         MEMWRITE: next = bus.mem_ready ? FETCH : MEMWRITE;
         EXECR, EXECI, JAL, UPPER: next = ALUWB;
         BRANCH:   next = (bus.Funct3[2:1] == 2'b01) ? TRAP : FETCH;
         JALR:     next = JAL;
         HALT:     next = bus.halt_req ? HALT : FETCH;
         TRAP:     next = TRAP;
         default:  next = FETCH;
      endcase
   end
   always_comb begin
      {pcw, adr, irw, memw, regw} = '0;
      {res, sa, sb} = '0;
      alu = ALU_ADD;
      imm = 4'd0;
      if (!Reset)
         case (state)
            FETCH: begin
               // a pending halt wins over the access so no enable fires on the way out
               pcw = bus.mem_ready & ~bus.halt_req;
               irw = bus.mem_ready & ~bus.halt_req;
               res = 2'b10;
               sb  = 2'b10;
            end
            DECODE: begin
               sa  = 2'b01;
               sb  = 2'b01;
               imm = (bus.Op == OP_BR) ? 4'd2 : (bus.Op == OP_JAL) ? 4'd3 : 4'd0;
            end
            MEMADR: begin
               sa  = 2'b10;
               sb  = 2'b01;
               imm = (bus.Op == OP_STORE) ? 4'd1 : 4'd0;
            end
            MEMREAD: adr = 1'b1;
            MEMWB: begin
               res  = 2'b01;
               regw = 1'b1;
            end
            MEMWRITE: begin
               adr  = 1'b1;
               memw = 1'b1;
            end
            EXECR: begin
               sa  = 2'b10;
               alu = alu_map(bus.Funct3, bus.Funct7[5]);
            end
            EXECI: begin
               sa  = 2'b10;
               sb  = 2'b01;
               alu = alu_map(bus.Funct3, bus.Funct3 == 3'b101 && bus.Funct7[5]);
            end
            ALUWB: regw = 1'b1;
            BRANCH: begin
               sa  = 2'b10;
               imm = 4'd2;
               alu = bus.Funct3[2] ? (bus.Funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
               // beq/bge/bgeu take on Zero, bne/blt/bltu on !Zero; 010/011 are illegal
               pcw = (bus.Funct3[2:1] != 2'b01) & (bus.Zero ^ bus.Funct3[0] ^ bus.Funct3[2]);
            end
            JAL: begin
               pcw = 1'b1;
               sa  = 2'b01;
               sb  = 2'b10;
            end
            JALR: begin
               sa = 2'b10;
               sb = 2'b01;
            end
            UPPER: begin
               sa  = (bus.Op == OP_LUI) ? 2'b11 : 2'b01;
               sb  = 2'b01;
               imm = 4'd4;
            end
            default: ;
         endcase
   end
   assign bus.PCWrite    = pcw;
   assign bus.AdrSrc     = adr;
   assign bus.IRWrite    = irw;
   assign bus.MemWrite   = memw;
   assign bus.RegWrite   = regw;
   assign bus.ResultSrc  = res;
   assign bus.ALUSrcA    = sa;
   assign bus.ALUSrcB    = sb;
   assign bus.ALUControl = alu;
   assign bus.ImmSrc     = imm;
   assign bus.halted     = (state == HALT) || (state == TRAP);
   assign bus.state_out  = state;
endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// tb_riscv_multicycle_controller: scoreboard bench, per-cycle stimulus and expected outputs are queued then replayed.
module tb_riscv_multicycle_controller;
   typedef struct packed {
      logic [3:0] st;
      logic       pcw, adr, irw, memw, regw;
      logic [1:0] res, sa, sb;
      logic [3:0] alu, imm;
      logic       halted;
   } out_t;
   typedef struct packed {
      logic [3:0] ctl;
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
   } stim_t;
   typedef struct packed {
      stim_t s;
      out_t  o;
   } entry_t;
   logic clk = 0;
   logic Reset = 1;
   int pass_cnt = 0;
   int total_cnt = 0;
   logic [6:0] cur_op = '0;
   logic [2:0] cur_f3 = '0;
   logic [6:0] cur_f7 = '0;
   entry_t sb[$];
   out_t act;
   riscv_multicycle_controller_if bus();
   riscv_multicycle_controller dut (.Clock(clk), .Reset(Reset), .bus(bus));
   always #5 clk = ~clk;
   assign act = {bus.state_out, bus.PCWrite, bus.AdrSrc, bus.IRWrite, bus.MemWrite, bus.RegWrite,
                 bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc, bus.halted};
   function automatic out_t mk(input logic [3:0] st, input logic pcw, adr, irw, memw, regw,
                               input logic [1:0] res, sa, sbs, input logic [3:0] alu, imm);
      mk = {st, pcw, adr, irw, memw, regw, res, sa, sbs, alu, imm, (st == 4'd13 || st == 4'd14)};
   endfunction
   function automatic out_t z(input logic [3:0] st);
      z = mk(st, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction
   // ctl = {Reset, mem_ready, Zero, halt_req}
   task automatic push(input logic [3:0] ctl, input out_t o);
      sb.push_back({ctl, cur_op, cur_f3, cur_f7, o});
   endtask
   task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      cur_op = op;
      cur_f3 = f3;
      cur_f7 = f7;
   endtask
   out_t f_go, f_wt;
   initial begin
      f_go = mk(0, 1, 0, 1, 0, 0, 2, 0, 2, 0, 0);
      f_wt = mk(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0);
   end
   task automatic test_reset;
      entry_t e;
      int k = 0;
      set_ir(7'b0100011, 3'b010, 7'h00);
      push(4'b1000, z(0));
      push(4'b0100, f_go);
      push(4'b0100, mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      push(4'b0100, mk(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 1));
      push(4'b0000, mk(5, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
      push(4'b0000, mk(5, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
      push(4'b1000, z(5));
      push(4'b1000, z(0));
      push(4'b0000, f_wt);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         {Reset, bus.mem_ready, bus.Zero, bus.halt_req} = e.s.ctl;
         {bus.Op, bus.Funct3, bus.Funct7} = {e.s.op, e.s.f3, e.s.f7};
         #1;
         total_cnt++;
         if (act !== e.o) $display("FAIL reset step %0d: got %h want %h", k, act, e.o);
         else pass_cnt++;
         k++;
         @(posedge clk); #1;
      end
   endtask
   task automatic test_alu;
      entry_t e;
      int k = 0;
      logic [6:0] ops[8] = '{7'h33, 7'h33, 7'h33, 7'h33, 7'h13, 7'h13, 7'h13, 7'h13};
      logic [2:0] f3s[8] = '{3'b000, 3'b000, 3'b101, 3'b011, 3'b000, 3'b101, 3'b101, 3'b010};
      logic [6:0] f7s[8] = '{7'h00, 7'h20, 7'h20, 7'h00, 7'h20, 7'h20, 7'h00, 7'h00};
      logic [3:0] alus[8] = '{4'd0, 4'd1, 4'd9, 4'd6, 4'd0, 4'd9, 4'd8, 4'd5};
      for (int i = 0; i < 8; i++) begin
         set_ir(ops[i], f3s[i], f7s[i]);
         push(4'b0100, f_go);
         push(4'b0100, mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
         push(4'b0100, (i < 4) ? mk(6, 0, 0, 0, 0, 0, 0, 2, 0, alus[i], 0)
                               : mk(7, 0, 0, 0, 0, 0, 0, 2, 1, alus[i], 0));
         push(4'b0100, mk(8, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         {Reset, bus.mem_ready, bus.Zero, bus.halt_req} = e.s.ctl;
         {bus.Op, bus.Funct3, bus.Funct7} = {e.s.op, e.s.f3, e.s.f7};
         #1;
         total_cnt++;
         if (act !== e.o) $display("FAIL alu step %0d: got %h want %h", k, act, e.o);
         else pass_cnt++;
         k++;
         @(posedge clk); #1;
      end
   endtask
   task automatic test_load;
      entry_t e;
      int k = 0;
      set_ir(7'b0000011, 3'b010, 7'h00);
      push(4'b0100, f_go);
      push(4'b0100, mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      push(4'b0100, mk(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
      for (int i = 0; i < 3; i++) push(4'b0000, mk(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      push(4'b0100, mk(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      push(4'b0100, mk(4, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
      push(4'b0000, f_wt);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         {Reset, bus.mem_ready, bus.Zero, bus.halt_req} = e.s.ctl;
         {bus.Op, bus.Funct3, bus.Funct7} = {e.s.op, e.s.f3, e.s.f7};
         #1;
         total_cnt++;
         if (act !== e.o) $display("FAIL load step %0d: got %h want %h", k, act, e.o);
         else pass_cnt++;
         k++;
         @(posedge clk); #1;
      end
   endtask
   task automatic test_branch;
      entry_t e;
      int k = 0;
      logic [2:0] f3s[7] = '{3'b001, 3'b001, 3'b000, 3'b100, 3'b101, 3'b111, 3'b110};
      logic       zs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [3:0] alus[7] = '{4'd1, 4'd1, 4'd1, 4'd5, 4'd5, 4'd6, 4'd6};
      logic       tk[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 7; i++) begin
         set_ir(7'b1100011, f3s[i], 7'h00);
         push({2'b01, zs[i], 1'b0}, f_go);
         push({2'b01, zs[i], 1'b0}, mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2));
         push({2'b01, zs[i], 1'b0}, mk(9, tk[i], 0, 0, 0, 0, 0, 2, 0, alus[i], 2));
      end
      push(4'b0000, f_wt);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         {Reset, bus.mem_ready, bus.Zero, bus.halt_req} = e.s.ctl;
         {bus.Op, bus.Funct3, bus.Funct7} = {e.s.op, e.s.f3, e.s.f7};
         #1;
         total_cnt++;
         if (act !== e.o) $display("FAIL branch step %0d: got %h want %h", k, act, e.o);
         else pass_cnt++;
         k++;
         @(posedge clk); #1;
      end
   endtask
   task automatic test_jump_upper;
      entry_t e;
      int k = 0;
      set_ir(7'b1100111, 3'b000, 7'h00);
      push(4'b0100, f_go);
      push(4'b0100, mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      push(4'b0100, mk(11, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
      push(4'b0100, mk(10, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0));
      push(4'b0100, mk(8, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      set_ir(7'b1101111, 3'b000, 7'h00);
      push(4'b0100, f_go);
      push(4'b0100, mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 3));
      push(4'b0100, mk(10, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0));
      push(4'b0100, mk(8, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      set_ir(7'b0110111, 3'b000, 7'h00);
      push(4'b0100, f_go);
      push(4'b0100, mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      push(4'b0100, mk(12, 0, 0, 0, 0, 0, 0, 3, 1, 0, 4));
      push(4'b0100, mk(8, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      set_ir(7'b0010111, 3'b000, 7'h00);
      push(4'b0100, f_go);
      push(4'b0100, mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      push(4'b0100, mk(12, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4));
      push(4'b0100, mk(8, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      push(4'b0000, f_wt);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         {Reset, bus.mem_ready, bus.Zero, bus.halt_req} = e.s.ctl;
         {bus.Op, bus.Funct3, bus.Funct7} = {e.s.op, e.s.f3, e.s.f7};
         #1;
         total_cnt++;
         if (act !== e.o) $display("FAIL jump step %0d: got %h want %h", k, act, e.o);
         else pass_cnt++;
         k++;
         @(posedge clk); #1;
      end
   endtask
   task automatic test_halt;
      entry_t e;
      int k = 0;
      set_ir(7'b0110011, 3'b000, 7'h00);
      push(4'b0101, f_wt);
      push(4'b0101, z(13));
      push(4'b0001, z(13));
      push(4'b0000, z(13));
      push(4'b0000, f_wt);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         {Reset, bus.mem_ready, bus.Zero, bus.halt_req} = e.s.ctl;
         {bus.Op, bus.Funct3, bus.Funct7} = {e.s.op, e.s.f3, e.s.f7};
         #1;
         total_cnt++;
         if (act !== e.o) $display("FAIL halt step %0d: got %h want %h", k, act, e.o);
         else pass_cnt++;
         k++;
         @(posedge clk); #1;
      end
   endtask
   task automatic test_trap;
      entry_t e;
      int k = 0;
      set_ir(7'h7F, 3'b000, 7'h00);
      push(4'b0100, f_go);
      push(4'b0100, mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      push(4'b0101, z(14));
      push(4'b0100, z(14));
      push(4'b0101, z(14));
      push(4'b1000, z(14));
      push(4'b0000, f_wt);
      set_ir(7'b1100011, 3'b010, 7'h00);
      push(4'b0100, f_go);
      push(4'b0100, mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2));
      push(4'b0110, mk(9, 0, 0, 0, 0, 0, 0, 2, 0, 1, 2));
      push(4'b0100, z(14));
      push(4'b1000, z(14));
      push(4'b0000, f_wt);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         {Reset, bus.mem_ready, bus.Zero, bus.halt_req} = e.s.ctl;
         {bus.Op, bus.Funct3, bus.Funct7} = {e.s.op, e.s.f3, e.s.f7};
         #1;
         total_cnt++;
         if (act !== e.o) $display("FAIL trap step %0d: got %h want %h", k, act, e.o);
         else pass_cnt++;
         k++;
         @(posedge clk); #1;
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", pass_cnt, total_cnt);
      $fatal(1);
   end
   initial begin
      {bus.mem_ready, bus.Zero, bus.halt_req} = '0;
      {bus.Op, bus.Funct3, bus.Funct7} = '0;
      repeat (2) @(posedge clk);
      #1;
      test_reset;
      test_alu;
      test_load;
      test_branch;
      test_jump_upper;
      test_halt;
      test_trap;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/riscv_multicycle_controller.md
Name: riscv_multicycle_controller

Overview:
- Moore-style control FSM that sequences a shared-memory, multicycle RV32I datapath. It sits beside that datapath, which shares one memory port, one ALU, an instruction register (IR), and OldPC/A/B/ALUOut/Data registers.
- It decodes Op, Funct3 and Funct7 each instruction and drives every enable and select.
- It supports memory wait-states, a debug halt at instruction boundaries, and a sticky illegal-opcode trap.

Parameters:
- RESET_STATE, 4'd0, state entered on Reset (FETCH).

Ports:
- Clock  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Op  in  7  IR[6:0].
- Funct3  in  3  IR[14:12].
- Funct7  in  7  IR[31:25].
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- halt_req  in  1  debug halt request.
- PCWrite  out  1  PC load enable.
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
- IRWrite  out  1  IR/OldPC load enable.
- MemWrite  out  1  memory write strobe.
- RegWrite  out  1  register-file write enable.
- ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult.
- ALUSrcA  out  2  ALU A select: 00=PC, 01=OldPC, 10=A, 11=zero.
- ALUSrcB  out  2  ALU B select: 00=B, 01=ImmExt, 10=const 4.
- ALUControl  out  4  ALU operation: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra.
- ImmSrc  out  4  immediate format: 0=I, 1=S, 2=B, 3=J, 4=U.
- halted  out  1  state is HALT or TRAP.
- state_out  out  4  current state code.

Behaviour:
- State codes:
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5
  - EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11
  - UPPER 12, HALT 13, TRAP 14
  - Code 15 is unused and returns to FETCH.
- Reset:
  - Reset=1 forces the state to FETCH on the next edge.
  - While Reset=1, all enables (PCWrite, IRWrite, MemWrite, RegWrite) are 0 and every select/ALU output is 0.
  - Reset mid-access abandons the access. A write stalled in MEMWRITE is dropped.
- Default outputs: every output not listed for a state is 0.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - IRWrite and PCWrite = mem_ready. The state holds while mem_ready=0.
  - If halt_req=1 on entry cycle evaluation (before the access completes), go to HALT with no enables asserted.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, add. This computes OldPC+imm into ALUOut.
  - ImmSrc comes from Op: B for 1100011, J for 1101111, I otherwise.
- Next state from DECODE, by Op:
  - 0000011 → MEMADR; 0100011 → MEMADR.
  - 0110011 → EXECR; 0010011 → EXECI.
  - 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR.
  - 0110111 → UPPER; 0010111 → UPPER.
  - Any other Op → TRAP.
- MEMADR:
  - ALUSrcA=10, ALUSrcB=01, add; ImmSrc=I for loads, S for stores.
  - Next state: MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: AdrSrc=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE:
  - AdrSrc=1, MemWrite=1, held each cycle until mem_ready=1, then FETCH.
  - Exactly one accepted write per store.
- EXECR:
  - ALUSrcA=10, ALUSrcB=00.
  - ALU op: Funct3 000 gives add, or sub if Funct7[5]=1; 001 sll; 010 slt; 011 sltu; 100 xor; 101 srl, or sra if Funct7[5]=1; 110 or; 111 and.
- EXECI:
  - ALUSrcB=01, ImmSrc=I, same Funct3 map as EXECR.
  - sub is never selected.
  - Funct3=101 uses Funct7[5] to pick sra/srl.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, ResultSrc=00, ImmSrc=B.
  - ALU op: beq/bne use sub; blt/bge use slt; bltu/bgeu use sltu.
  - PCWrite: beq = Zero; bne = !Zero; blt/bltu = !Zero; bge/bgeu = Zero.
  - Funct3 010 or 011 → TRAP with PCWrite=0. Otherwise next state is FETCH.
- JAL:
  - ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then ALUWB.
  - Net effect: rd = OldPC+4, PC = target.
- JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc=I, add (ALUOut = rs1+imm), then JAL.
- UPPER:
  - ALUSrcA=11 for lui or 01 for auipc; ALUSrcB=01, ImmSrc=U, add, then ALUWB.
- HALT: no enables asserted. Stays while halt_req=1 and returns to FETCH when halt_req=0.
- TRAP: no enables asserted. Sticky until Reset; halt_req is ignored.
- Latency:
  - With mem_ready held at 1: R/I/U-type = 4 cycles, load = 5, store = 4, branch = 3.
  - JAL = 4 cycles, JALR = 5.

Test Plan:
- Reset held 2 cycles mid-MEMWRITE, mem_ready=0 → MemWrite=0 during reset; state_out=0 after release; no write accepted.
- add x3,x1,x2 (Op 0110011, F3 000, F7 0), mem_ready=1 → states 0,1,6,8; ALUControl=1 never seen; RegWrite=1 only in state 8.
- lw with mem_ready low 3 cycles in MEMREAD → state_out=3 for 4 cycles; AdrSrc=1 throughout; RegWrite pulses once in state 4.
- bne (F3 001) with Zero=0 then Zero=1 → PCWrite=1 in BRANCH for the first, 0 for the second; both return to state 0.
- jalr x1,0(x5) → states 0,1,11,10,8; PCWrite=1 only in FETCH and state 10; ResultSrc=00 in state 10.
- halt_req=1 during FETCH → state 13, halted=1, no enables; drop halt_req → state 0. Op=7'h7F → state 14 sticky despite halt_req toggling; Reset clears it.
